hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Tracks in-flight destination registers of the EX, MEM and WB stages in an internal shadow pipeline.
- Drives stall and flush controls for the PC, IF/ID and ID/EX registers, plus EX-stage forwarding selects.
- Counts stall and flush events for performance visibility.

---
 rtl/hazard_ctrl_pkg.sv | 14 +
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl_sat_counter.sv | 23 ++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: forwarding
// select encodings and default shadow-stage field widths.
package hazard_ctrl_pkg;

  localparam int DEF_REG_W = 5;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage decode inputs and pipeline control outputs of the hazard controller.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] RsD;
  logic [REG_W-1:0] RtD;
  logic [REG_W-1:0] RdD;
  logic             RFWE_D;
  logic             RFDSel_D;
  logic             MtoRFsel_D;
  logic             jump_D;
  logic             branch_taken_E;
  logic             mem_busy;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output RsD, RtD, RdD, RFWE_D, RFDSel_D, MtoRFsel_D, jump_D,
           branch_taken_E, mem_busy,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  RsD, RtD, RdD, RFWE_D, RFDSel_D, MtoRFsel_D, jump_D,
           branch_taken_E, mem_busy,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hazard_ctrl_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing and EX forwarding for the 5-stage MIPS core, driven
// by a shadow copy of the destination registers held in EX, MEM and WB.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = DEF_REG_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       CLK,
  input  logic       CLR,
  hazard_ctrl_if.slave bus
);

  logic             r_d_valid;
  logic             r_e_valid, r_e_wr, r_e_load;
  logic [REG_W-1:0] r_e_dst, r_e_rs, r_e_rt;
  logic             r_m_valid, r_m_wr, r_m_load;
  logic [REG_W-1:0] r_m_dst;
  logic             r_w_valid, r_w_wr;
  logic [REG_W-1:0] r_w_dst;

  logic [REG_W-1:0] w_dst_d;
  logic             w_lw_hazard;
  logic             w_stall_f, w_stall_d, w_flush_d, w_flush_e;
  logic             w_stall_inc, w_flush_inc;
  fwd_sel_e         w_fwd_a, w_fwd_b;

  assign w_dst_d = bus.RFDSel_D ? bus.RdD : bus.RtD;

  assign w_lw_hazard = r_d_valid & r_e_valid & r_e_load & (r_e_dst != '0) &
                       ((r_e_dst == bus.RsD) | (r_e_dst == bus.RtD));

  // Controls are forced low while CLR is held so nothing escapes during reset
  always_comb begin
    w_stall_f   = 1'b0;
    w_stall_d   = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (CLR) begin
      if (bus.mem_busy) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
      end else if (bus.branch_taken_E) begin
        w_flush_d   = 1'b1;
        w_flush_e   = 1'b1;
        w_flush_inc = 1'b1;
      end else if (w_lw_hazard) begin
        w_stall_f   = 1'b1;
        w_stall_d   = 1'b1;
        w_flush_e   = 1'b1;
        w_stall_inc = 1'b1;
      end else if (bus.jump_D && r_d_valid) begin
        w_flush_d   = 1'b1;
        w_flush_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_d_valid <= 1'b0;
      r_e_valid <= 1'b0;
      r_e_wr    <= 1'b0;
      r_e_load  <= 1'b0;
      r_e_dst   <= '0;
      r_e_rs    <= '0;
      r_e_rt    <= '0;
      r_m_valid <= 1'b0;
      r_m_wr    <= 1'b0;
      r_m_load  <= 1'b0;
      r_m_dst   <= '0;
      r_w_valid <= 1'b0;
      r_w_wr    <= 1'b0;
      r_w_dst   <= '0;
    end else if (!bus.mem_busy) begin
      r_w_valid <= r_m_valid;
      r_w_wr    <= r_m_wr;
      r_w_dst   <= r_m_dst;
      r_m_valid <= r_e_valid;
      r_m_wr    <= r_e_wr;
      r_m_load  <= r_e_load;
      r_m_dst   <= r_e_dst;
      if (w_flush_e) begin
        r_e_valid <= 1'b0;
        r_e_wr    <= 1'b0;
        r_e_load  <= 1'b0;
        r_e_dst   <= '0;
        r_e_rs    <= '0;
        r_e_rt    <= '0;
      end else begin
        r_e_valid <= r_d_valid;
        r_e_wr    <= bus.RFWE_D & r_d_valid;
        r_e_load  <= bus.MtoRFsel_D & r_d_valid;
        r_e_dst   <= w_dst_d;
        r_e_rs    <= bus.RsD;
        r_e_rt    <= bus.RtD;
      end
      if (w_flush_d) begin
        r_d_valid <= 1'b0;
      end else if (!w_stall_d) begin
        r_d_valid <= 1'b1;
      end
    end
  end

  // A load still in MEM has no result yet, so only WB may supply its data
  function automatic fwd_sel_e fwd_sel(input logic [REG_W-1:0] src);
    if ((src != '0) && r_m_valid && r_m_wr && !r_m_load && (r_m_dst == src)) begin
      return FWD_MEM;
    end else if ((src != '0) && r_w_valid && r_w_wr && (r_w_dst == src)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  always_comb begin
    w_fwd_a = fwd_sel(r_e_rs);
    w_fwd_b = fwd_sel(r_e_rt);
  end

  assign bus.StallF    = w_stall_f;
  assign bus.StallD    = w_stall_d;
  assign bus.FlushD    = w_flush_d;
  assign bus.FlushE    = w_flush_e;
  assign bus.ForwardAE = w_fwd_a;
  assign bus.ForwardBE = w_fwd_b;

  hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk   (CLK),
    .i_rst_n (CLR),
    .i_inc   (w_stall_inc),
    .o_cnt   (bus.stall_cnt)
  );

  hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk   (CLK),
    .i_rst_n (CLR),
    .i_inc   (w_flush_inc),
    .o_cnt   (bus.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against an instruction-level model.
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif ();

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (hif)
  );

  typedef struct {
    bit v;
    bit wr;
    bit ld;
    int dst;
    int rs;
    int rt;
  } ins_t;

  ins_t mdl_e, mdl_m, mdl_w;
  bit   mdl_dv;
  int   mdl_sc, mdl_fc;

  int n_checks = 0;
  int n_errors = 0;

  bit x_sf, x_sd, x_fd, x_fe;
  int x_fa, x_fb;
  logic [31:0] o_sf, o_sd, o_fd, o_fe, o_fa, o_fb, o_sc, o_fc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    mdl_e  = '{default: 0};
    mdl_m  = '{default: 0};
    mdl_w  = '{default: 0};
    mdl_dv = 1'b0;
    mdl_sc = 0;
    mdl_fc = 0;
  endfunction

  // Youngest producer that has its value available wins; $0 never forwards
  function automatic int fwd_of(input int src);
    if (src == 0) return 0;
    if (mdl_m.v && mdl_m.wr && !mdl_m.ld && mdl_m.dst == src) return 2;
    if (mdl_w.v && mdl_w.wr && mdl_w.dst == src) return 1;
    return 0;
  endfunction

  function automatic void mdl_expect();
    bit hz;
    int rs, rt;
    x_sf = 0; x_sd = 0; x_fd = 0; x_fe = 0; x_fa = 0; x_fb = 0;
    rs = int'(hif.RsD);
    rt = int'(hif.RtD);
    if (clr) begin
      hz = mdl_dv && mdl_e.v && mdl_e.ld && mdl_e.dst != 0 &&
           (mdl_e.dst == rs || mdl_e.dst == rt);
      if (hif.mem_busy) begin
        x_sf = 1; x_sd = 1;
      end else if (hif.branch_taken_E) begin
        x_fd = 1; x_fe = 1;
      end else if (hz) begin
        x_sf = 1; x_sd = 1; x_fe = 1;
      end else if (hif.jump_D && mdl_dv) begin
        x_fd = 1;
      end
      x_fa = fwd_of(mdl_e.rs);
      x_fb = fwd_of(mdl_e.rt);
    end
  endfunction

  function automatic void mdl_advance();
    ins_t ne;
    if (hif.mem_busy) return;
    if (x_fe) begin
      ne = '{default: 0};
    end else begin
      ne.v   = mdl_dv;
      ne.wr  = hif.RFWE_D && mdl_dv;
      ne.ld  = hif.MtoRFsel_D && mdl_dv;
      ne.dst = hif.RFDSel_D ? int'(hif.RdD) : int'(hif.RtD);
      ne.rs  = int'(hif.RsD);
      ne.rt  = int'(hif.RtD);
    end
    mdl_w = mdl_m;
    mdl_m = mdl_e;
    mdl_e = ne;
    if (x_fd) mdl_dv = 1'b0;
    else if (!x_sd) mdl_dv = 1'b1;
    if (x_fd && mdl_fc < MAXC) mdl_fc++;
    if (x_fe && !x_fd && mdl_sc < MAXC) mdl_sc++;
  endfunction

  task automatic drive(input int rs, input int rt, input int rd, input bit we,
                       input bit sel, input bit ld, input bit jmp, input bit br,
                       input bit busy);
    hif.RsD            = REG_W'(rs);
    hif.RtD            = REG_W'(rt);
    hif.RdD            = REG_W'(rd);
    hif.RFWE_D         = we;
    hif.RFDSel_D       = sel;
    hif.MtoRFsel_D     = ld;
    hif.jump_D         = jmp;
    hif.branch_taken_E = br;
    hif.mem_busy       = busy;
  endtask

  task automatic capture();
    o_sf = 32'(hif.StallF);
    o_sd = 32'(hif.StallD);
    o_fd = 32'(hif.FlushD);
    o_fe = 32'(hif.FlushE);
    o_fa = 32'(hif.ForwardAE);
    o_fb = 32'(hif.ForwardBE);
    o_sc = 32'(hif.stall_cnt);
    o_fc = 32'(hif.flush_cnt);
  endtask

  // One pipeline cycle: check mid-cycle, then let model and DUT advance together
  task automatic step();
    @(negedge clk);
    mdl_expect();
    capture();
    check("StallF", o_sf, 32'(x_sf));
    check("StallD", o_sd, 32'(x_sd));
    check("FlushD", o_fd, 32'(x_fd));
    check("FlushE", o_fe, 32'(x_fe));
    check("ForwardAE", o_fa, 32'(x_fa));
    check("ForwardBE", o_fb, 32'(x_fb));
    check("stall_cnt", o_sc, 32'(mdl_sc));
    check("flush_cnt", o_fc, 32'(mdl_fc));
    @(posedge clk);
    if (clr) mdl_advance();
    #1;
  endtask

  initial begin
    clr = 1'b0;
    mdl_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    capture();
    check("rst_StallF", o_sf, 0);
    check("rst_stall_cnt", o_sc, 0);
    clr = 1'b1;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    // load-use on $5
    drive(1, 5, 0, 1, 0, 1, 0, 0, 0); step();
    drive(5, 2, 6, 1, 1, 0, 0, 0, 0); step();
    check("lu_StallF", o_sf, 1);
    check("lu_StallD", o_sd, 1);
    check("lu_FlushE", o_fe, 1);
    check("lu_FlushD", o_fd, 0);
    drive(5, 2, 6, 1, 1, 0, 0, 0, 0); step();
    check("lu_once", o_sf, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    check("lu_fwd_wb", o_fa, 1);
    check("lu_cnt", o_sc, 1);

    // $4 produced in both MEM and WB
    drive(1, 2, 4, 1, 1, 0, 0, 0, 0); step();
    drive(1, 2, 4, 1, 1, 0, 0, 0, 0); step();
    drive(4, 4, 7, 1, 1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    check("prio_A", o_fa, 2);
    check("prio_B", o_fb, 2);
    drive(1, 2, 0, 1, 1, 0, 0, 0, 0); step();
    drive(1, 2, 0, 1, 1, 0, 0, 0, 0); step();
    drive(0, 0, 3, 1, 1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    check("r0_A", o_fa, 0);
    check("r0_B", o_fb, 0);

    // taken branch coincident with load-use
    drive(1, 5, 0, 1, 0, 1, 0, 0, 0); step();
    drive(5, 2, 6, 1, 1, 0, 0, 1, 0); step();
    check("br_FlushD", o_fd, 1);
    check("br_FlushE", o_fe, 1);
    check("br_StallF", o_sf, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    check("br_flush_cnt", o_fc, 1);
    check("br_stall_cnt", o_sc, 1);
    check("jmp_dv0", o_fd, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    check("jmp_flush", o_fd, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    check("jmp_no_repeat", o_fd, 0);
    check("jmp_flush_cnt", o_fc, 2);

    // memory busy during a load-use hazard
    drive(1, 5, 0, 1, 0, 1, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(5, 2, 6, 1, 1, 0, 0, 0, 1); step();
      check("busy_StallF", o_sf, 1);
      check("busy_StallD", o_sd, 1);
      check("busy_FlushE", o_fe, 0);
      check("busy_cnt", o_sc, 1);
    end
    drive(5, 2, 6, 1, 1, 0, 0, 0, 0); step();
    check("unbusy_stall", o_sf, 1);
    check("unbusy_FlushE", o_fe, 1);
    drive(5, 2, 6, 1, 1, 0, 0, 0, 0); step();
    check("unbusy_once", o_sf, 0);
    check("unbusy_cnt", o_sc, 2);

    // asynchronous reset with a load in EX and the hazard present
    drive(1, 5, 0, 1, 0, 1, 0, 0, 0); step();
    drive(5, 2, 6, 1, 1, 0, 0, 0, 0);
    clr = 1'b0;
    mdl_reset();
    #1;
    capture();
    check("arst_StallF", o_sf, 0);
    check("arst_FlushE", o_fe, 0);
    check("arst_stall_cnt", o_sc, 0);
    step();
    clr = 1'b1;
    drive(3, 0, 0, 0, 0, 0, 0, 0, 0); step();
    check("post_rst_stall", o_sf, 0);
    check("post_rst_fwd", o_fa, 0);

    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0));
      if (!clr) begin
        clr = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        clr = 1'b0;
        mdl_reset();
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
